// File: rtl/decode_issue_ctrl.sv
// -----------------------------------------------------------------------------
// decode_issue_ctrl
//
// Decode-stage controller sitting between fetch and execute. Each accepted
// instruction is decoded combinationally (immediate format from the opcode,
// sign-extended immediate) and captured into a 2-entry skid buffer. The head
// entry drives every out_* port directly from flops.
//
// Build option:
//   DECODE_ILLEGAL_CHECK_EN - adds the out_illegal port and a per-entry
//                             illegal-opcode flag.
//
// Ports:
//   clk, rst      rising-edge clock; asynchronous active-high reset
//   flush         drop every buffered and same-cycle incoming instruction
//   in_valid/in_ready/in_instr/in_pc     fetch-side handshake and payload
//   out_valid/out_ready                  execute-side handshake
//   out_pc, out_instr, out_imm, out_imm_type, out_rd, out_rs1, out_rs2
//                                        decoded fields of the head entry
//   out_illegal   (optional) head entry carries an illegal opcode
// -----------------------------------------------------------------------------
module decode_issue_ctrl #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_instr,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_imm_type,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2
`ifdef DECODE_ILLEGAL_CHECK_EN
  ,
  output logic            out_illegal
`endif
);

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_type_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic [XLEN-1:0] imm;
    imm_type_e       imm_type;
`ifdef DECODE_ILLEGAL_CHECK_EN
    logic            illegal;
`endif
  } entry_t;

  // Buffer state: r_main is the head, r_skid the second entry.
  logic [1:0] r_count;
  entry_t     r_main;
  entry_t     r_skid;

  entry_t      w_dec;
  logic [31:0] w_imm32;
  logic        w_enq;
  logic        w_deq;

  // ---------------------------------------------------------------------------
  // Combinational decode of the incoming instruction
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    w_dec          = '0;
    w_dec.pc       = in_pc;
    w_dec.instr    = in_instr;
    w_dec.imm_type = IMM_NONE;

    case (in_instr[6:0])
      7'b0110111, 7'b0010111: w_dec.imm_type = IMM_U;
      7'b1101111:             w_dec.imm_type = IMM_J;
      7'b1100111, 7'b0000011, 7'b0010011,
      7'b0001111, 7'b1110011: w_dec.imm_type = IMM_I;
      7'b0100011:             w_dec.imm_type = IMM_S;
      7'b1100011:             w_dec.imm_type = IMM_B;
`ifdef DECODE_ILLEGAL_CHECK_EN
      // R-type carries no immediate but is a legal instruction.
      7'b0110011:             w_dec.imm_type = IMM_NONE;
      default:                w_dec.illegal  = 1'b1;
`else
      default:                w_dec.imm_type = IMM_NONE;
`endif
    endcase

    // Assemble a 32-bit immediate, then sign-extend from bit 31 to XLEN.
    case (w_dec.imm_type)
      IMM_I:   w_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
      IMM_S:   w_imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      IMM_B:   w_imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                          in_instr[30:25], in_instr[11:8], 1'b0};
      IMM_U:   w_imm32 = {in_instr[31:12], 12'b0};
      IMM_J:   w_imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                          in_instr[20], in_instr[30:21], 1'b0};
      default: w_imm32 = 32'd0;
    endcase
    w_dec.imm = XLEN'(signed'(w_imm32));
  end

  // ---------------------------------------------------------------------------
  // Handshake: in_ready depends on registered occupancy only, so there is no
  // combinational path from out_ready back to fetch.
  // ---------------------------------------------------------------------------
  assign in_ready  = (32'(r_count) < DEPTH);
  assign out_valid = (r_count != 2'd0);
  assign w_enq     = in_valid & in_ready;
  assign w_deq     = out_valid & out_ready;

  // ---------------------------------------------------------------------------
  // Skid buffer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: both entries are reset because their contents drive the outputs,
      // which must read as zero out of reset.
      r_count <= 2'd0;
      r_main  <= '0;
      r_skid  <= '0;
    end else if (flush) begin
      // Same-cycle enqueue is dropped; stale entry data stays hidden behind
      // out_valid=0.
      r_count <= 2'd0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      case (r_count)
        2'd0: begin
          if (w_enq) begin
            r_main  <= w_dec;
            r_count <= 2'd1;
          end
        end
        2'd1: begin
          if (w_enq && w_deq) begin
            r_main <= w_dec;
          end else if (w_enq) begin
            r_skid  <= w_dec;
            r_count <= 2'd2;
          end else if (w_deq) begin
            r_count <= 2'd0;
          end
        end
        default: begin
          // Full: in_ready is low, so only a dequeue can happen.
          if (w_deq) begin
            r_main  <= r_skid;
            r_count <= 2'd1;
          end
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Head entry drives the outputs; register fields are slices of the stored
  // instruction.
  // ---------------------------------------------------------------------------
  assign out_pc       = r_main.pc;
  assign out_instr    = r_main.instr;
  assign out_imm      = r_main.imm;
  assign out_imm_type = r_main.imm_type;
  assign out_rd       = r_main.instr[11:7];
  assign out_rs1      = r_main.instr[19:15];
  assign out_rs2      = r_main.instr[24:20];
`ifdef DECODE_ILLEGAL_CHECK_EN
  assign out_illegal  = r_main.illegal;
`endif

endmodule

// File: tb/tb_decode_issue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_decode_issue_ctrl
//
// Directed self-checking bench for decode_issue_ctrl: reset state, immediate
// formats, back-to-back throughput, backpressure, flush, asynchronous reset
// and (when DECODE_ILLEGAL_CHECK_EN is defined) the illegal-opcode flag.
// -----------------------------------------------------------------------------
module tb_decode_issue_ctrl;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            flush = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [31:0]     in_instr = 32'd0;
  logic [XLEN-1:0] in_pc = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [XLEN-1:0] out_pc;
  logic [31:0]     out_instr;
  logic [XLEN-1:0] out_imm;
  logic [2:0]      out_imm_type;
  logic [4:0]      out_rd;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
`ifdef DECODE_ILLEGAL_CHECK_EN
  logic            out_illegal;
`endif

  int n_cmp = 0;
  int n_err = 0;

  decode_issue_ctrl #(.XLEN(XLEN), .DEPTH(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_instr     (in_instr),
    .in_pc        (in_pc),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_pc       (out_pc),
    .out_instr    (out_instr),
    .out_imm      (out_imm),
    .out_imm_type (out_imm_type),
    .out_rd       (out_rd),
    .out_rs1      (out_rs1),
    .out_rs2      (out_rs2)
`ifdef DECODE_ILLEGAL_CHECK_EN
    ,
    .out_illegal  (out_illegal)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and sample 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // ---------------- reset state ----------------
    step();
    step();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_out_pc",    64'(out_pc),    64'd0);
    check("rst_out_instr", 64'(out_instr), 64'd0);
    check("rst_out_imm",   64'(out_imm),   64'd0);
    check("rst_imm_type",  64'(out_imm_type), 64'd0);
    check("rst_rd",        64'(out_rd),    64'd0);
`ifdef DECODE_ILLEGAL_CHECK_EN
    check("rst_illegal",   64'(out_illegal), 64'd0);
`endif
    rst = 1'b0;

    // ---------------- addi x1,x0,-1 ----------------
    in_valid = 1'b1; in_instr = 32'hFFF00093; in_pc = 32'h100; out_ready = 1'b1;
    step();
    check("addi_valid", 64'(out_valid),    64'd1);
    check("addi_imm",   64'(out_imm),      64'hFFFFFFFF);
    check("addi_type",  64'(out_imm_type), 64'd1);
    check("addi_rd",    64'(out_rd),       64'd1);
    check("addi_rs1",   64'(out_rs1),      64'd0);
    check("addi_pc",    64'(out_pc),       64'h100);

    // ---------------- back-to-back beq / lui / sw ----------------
    in_instr = 32'hFE000EE3; in_pc = 32'h104;
    step();
    check("beq_valid", 64'(out_valid),    64'd1);
    check("beq_imm",   64'(out_imm),      64'hFFFFFFFC);
    check("beq_type",  64'(out_imm_type), 64'd3);
    check("beq_pc",    64'(out_pc),       64'h104);

    in_instr = 32'h123452B7; in_pc = 32'h108;
    step();
    check("lui_valid", 64'(out_valid),    64'd1);
    check("lui_imm",   64'(out_imm),      64'h12345000);
    check("lui_type",  64'(out_imm_type), 64'd4);
    check("lui_rd",    64'(out_rd),       64'd5);

    in_instr = 32'hFE21AC23; in_pc = 32'h10C;
    step();
    check("sw_valid", 64'(out_valid),    64'd1);
    check("sw_imm",   64'(out_imm),      64'hFFFFFFF8);
    check("sw_type",  64'(out_imm_type), 64'd2);
    check("sw_rs1",   64'(out_rs1),      64'd3);
    check("sw_rs2",   64'(out_rs2),      64'd2);
    check("sw_instr", 64'(out_instr),    64'hFE21AC23);

    in_valid = 1'b0;
    step();
    check("drain_valid", 64'(out_valid), 64'd0);

    // ---------------- backpressure ----------------
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h00100093; in_pc = 32'h200;
    step();
    check("bp1_in_ready", 64'(in_ready), 64'd1);
    check("bp1_pc",       64'(out_pc),   64'h200);

    in_instr = 32'h00200113; in_pc = 32'h204;
    step();
    check("bp2_in_ready", 64'(in_ready), 64'd0);
    check("bp2_pc",       64'(out_pc),   64'h200);
    check("bp2_imm",      64'(out_imm),  64'd1);

    in_instr = 32'h00300193; in_pc = 32'h208;
    step();
    check("bp3_in_ready", 64'(in_ready),  64'd0);
    check("bp3_pc_hold",  64'(out_pc),    64'h200);
    check("bp3_valid",    64'(out_valid), 64'd1);

    out_ready = 1'b1;
    step();
    check("bp_deq1_pc",    64'(out_pc),   64'h204);
    check("bp_deq1_imm",   64'(out_imm),  64'd2);
    check("bp_deq1_ready", 64'(in_ready), 64'd1);

    step();
    check("bp_deq2_pc",  64'(out_pc),  64'h208);
    check("bp_deq2_imm", 64'(out_imm), 64'd3);
    check("bp_deq2_rd",  64'(out_rd),  64'd3);

    in_valid = 1'b0;
    step();
    check("bp_empty", 64'(out_valid), 64'd0);

    // ---------------- flush ----------------
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h00100093; in_pc = 32'h300;
    step();
    in_pc = 32'h304;
    step();
    check("fl_full_ready", 64'(in_ready), 64'd0);

    flush = 1'b1; in_pc = 32'h308;
    step();
    check("fl_valid", 64'(out_valid), 64'd0);
    check("fl_ready", 64'(in_ready),  64'd1);

    // Enqueue offered in the same cycle as flush must be discarded.
    in_pc = 32'h30C;
    step();
    check("fl_enq_drop", 64'(out_valid), 64'd0);

    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step();
    check("fl_never_appears", 64'(out_valid), 64'd0);

    // ---------------- asynchronous reset ----------------
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h00100093; in_pc = 32'h400;
    step();
    in_valid = 1'b0;
    check("ar_pre_valid", 64'(out_valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("ar_valid_now", 64'(out_valid), 64'd0);
    check("ar_pc_now",    64'(out_pc),    64'd0);
    #1 rst = 1'b0;

    in_valid = 1'b1; in_instr = 32'h0000006F; in_pc = 32'h500; out_ready = 1'b1;
    step();
    check("jal_valid", 64'(out_valid),    64'd1);
    check("jal_type",  64'(out_imm_type), 64'd5);
    check("jal_imm",   64'(out_imm),      64'd0);
    check("jal_pc",    64'(out_pc),       64'h500);

`ifdef DECODE_ILLEGAL_CHECK_EN
    // ---------------- illegal-opcode flag ----------------
    in_instr = 32'h00000033; in_pc = 32'h600;
    step();
    check("r_illegal", 64'(out_illegal),  64'd0);
    check("r_type",    64'(out_imm_type), 64'd0);
    check("r_imm",     64'(out_imm),      64'd0);

    in_instr = 32'h0000007F; in_pc = 32'h604;
    step();
    check("bad_illegal", 64'(out_illegal),  64'd1);
    check("bad_imm",     64'(out_imm),      64'd0);
    check("bad_type",    64'(out_imm_type), 64'd0);
    check("bad_valid",   64'(out_valid),    64'd1);
`endif

    in_valid = 1'b0;
    step();
    check("final_empty", 64'(out_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
